// File: rtl/tick_wait_counter.sv
// tick_wait_counter: independent per-channel request/ack event counters with a blocked hold-off.
// Optional macro TICK_WAIT_TIMEOUT_EN compiles in the WAIT_MAX expiry path and the timeout flag.

module tick_wait_chan #(
    parameter int CNT_W  = 8,
    parameter int TARGET = 25
`ifdef TICK_WAIT_TIMEOUT_EN
    , parameter int WAIT_MAX = 15
`endif
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             req,
    input  logic             blocked,
    input  logic             clear,
    output logic             ack,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] TGT = CNT_W'(TARGET);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_d;
    logic             ack_d;
    logic             done_d;

`ifdef TICK_WAIT_TIMEOUT_EN
    localparam logic [7:0] WMAX = 8'(WAIT_MAX);
    logic [7:0] wcnt_q, wcnt_d;
    logic       timeout_d;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            wcnt_q  <= '0;
            timeout <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            timeout <= timeout_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q <= S_IDLE;
            count   <= '0;
            ack     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            ack     <= ack_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count;
        ack_d   = 1'b0;
        done_d  = done;
`ifdef TICK_WAIT_TIMEOUT_EN
        wcnt_d    = wcnt_q;
        timeout_d = timeout;
`endif
        // clear outranks anything the FSM would have done this cycle
        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            done_d  = 1'b0;
`ifdef TICK_WAIT_TIMEOUT_EN
            wcnt_d    = '0;
            timeout_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_d = S_WAIT;
`ifdef TICK_WAIT_TIMEOUT_EN
                        wcnt_d = '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (!blocked) begin
                        count_d = count + ONE;
                        ack_d   = 1'b1;
                        if (count_d == TGT) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
`ifdef TICK_WAIT_TIMEOUT_EN
                    else if (wcnt_q == WMAX) begin
                        timeout_d = 1'b1;
                        ack_d     = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
`endif
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end
endmodule

module tick_wait_counter #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8,
    parameter int TARGET   = 25,
    parameter int WAIT_MAX = 15
) (
    input  logic                      clk,
    input  logic                      reset_l,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS-1:0]       blocked,
    input  logic [CHANNELS-1:0]       clear,
    output logic [CHANNELS-1:0]       ack,
    output logic [CHANNELS*CNT_W-1:0] count,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       timeout
);
    if (CHANNELS < 1 || CHANNELS > 8 || WAIT_MAX < 1 || WAIT_MAX > 255 ||
        TARGET < 1 || TARGET >= (1 << CNT_W)) begin : g_param_check
        $error("tick_wait_counter: parameter out of legal range");
    end

    // one FSM per channel; the instance array slices count so channel i lands at [i*CNT_W +: CNT_W]
    tick_wait_chan #(
        .CNT_W   (CNT_W),
        .TARGET  (TARGET)
`ifdef TICK_WAIT_TIMEOUT_EN
        , .WAIT_MAX(WAIT_MAX)
`endif
    ) u_chan [CHANNELS-1:0] (
        .clk     (clk),
        .reset_l (reset_l),
        .req     (req),
        .blocked (blocked),
        .clear   (clear),
        .ack     (ack),
        .count   (count),
        .done    (done),
        .timeout (timeout)
    );
endmodule

// File: tb/tb_tick_wait_counter.sv
// Self-checking bench for tick_wait_counter: vector table, directed corner sequences and a
// randomized run against a behavioural model. Honours TICK_WAIT_TIMEOUT_EN like the design.

module tb_tick_wait_counter;
    localparam int CH   = 2;
    localparam int CW   = 8;
    localparam int TGT  = 25;
    localparam int WMAX = 15;
`ifdef TICK_WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_l;
    logic [CH-1:0]    req, blocked, clear;
    logic [CH-1:0]    ack, done, timeout;
    logic [CH*CW-1:0] count;

    always #5 clk = ~clk;

    tick_wait_counter #(
        .CHANNELS (CH),
        .CNT_W    (CW),
        .TARGET   (TGT),
        .WAIT_MAX (WMAX)
    ) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .req     (req),
        .blocked (blocked),
        .clear   (clear),
        .ack     (ack),
        .count   (count),
        .done    (done),
        .timeout (timeout)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model: a request is "pending" from acceptance until it retires
    int m_cnt  [CH];
    int m_wait [CH];
    bit m_pend [CH];
    bit m_done [CH];
    bit m_tout [CH];
    bit m_ack  [CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < CH; i++) begin
            m_ack[i] = 1'b0;
            if (!reset_l) begin
                m_cnt[i] = 0; m_wait[i] = 0; m_pend[i] = 0; m_done[i] = 0; m_tout[i] = 0;
            end else if (clear[i]) begin
                m_cnt[i] = 0; m_wait[i] = 0; m_pend[i] = 0; m_done[i] = 0; m_tout[i] = 0;
            end else if (m_pend[i]) begin
                if (!blocked[i]) begin
                    m_cnt[i]  = m_cnt[i] + 1;
                    m_ack[i]  = 1'b1;
                    m_pend[i] = 1'b0;
                    m_done[i] = (m_cnt[i] == TGT);
                end else if (TO_EN && m_wait[i] == WMAX) begin
                    m_tout[i] = 1'b1;
                    m_ack[i]  = 1'b1;
                    m_pend[i] = 1'b0;
                end else begin
                    m_wait[i] = m_wait[i] + 1;
                end
            end else if (!m_done[i] && req[i]) begin
                m_pend[i] = 1'b1;
                m_wait[i] = 0;
            end
        end
    endtask

    task automatic tick();
        logic [CH-1:0]    ea, ed, et;
        logic [CH*CW-1:0] ec;
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < CH; i++) begin
            ea[i] = m_ack[i];
            ed[i] = m_done[i];
            et[i] = m_tout[i];
            ec[i*CW +: CW] = CW'(m_cnt[i]);
        end
        check("model_ack", ack, ea);
        check("model_done", done, ed);
        check("model_timeout", timeout, et);
        check("model_count", count, ec);
    endtask

    // pulse req0; blocked0 held high on ticks 1..blk_ticks; lat = tick on which ack0 first appears
    task automatic run_req(input int blk_ticks, input int limit, output int lat);
        lat = -1;
        req[0] = 1'b1;
        blocked[0] = (blk_ticks > 0);
        for (int n = 1; n <= limit; n++) begin
            tick();
            req[0] = 1'b0;
            if (n >= blk_ticks) blocked[0] = 1'b0;
            if (ack[0] === 1'b1) begin
                lat = n;
                break;
            end
        end
        blocked[0] = 1'b0;
    endtask

    typedef struct {
        logic          rl;
        logic [CH-1:0] rq, bl, cl;
        logic [CH-1:0] e_ack, e_done;
        logic [CW-1:0] e_c0, e_c1;
    } vec_t;

    vec_t tbl [12];
    int   lat;
    int   blk_left [CH];

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0};
        tbl[1]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 8'd1, 8'd0};
        tbl[2]  = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0};
        tbl[3]  = '{1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0};
        tbl[4]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 8'd2, 8'd1};
        tbl[5]  = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 8'd0, 8'd1};
        tbl[6]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 8'd1};
        tbl[7]  = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 8'd1};
        tbl[8]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0};
        tbl[9]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0};
        tbl[10] = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0};
        tbl[11] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 8'd1, 8'd0};

        // reset overrides any activity on the inputs
        reset_l = 1'b0; req = 2'b11; blocked = 2'b01; clear = 2'b10;
        tick();
        tick();
        check("rst_ack", ack, 0);
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);

        // vector table; first req is on the first edge with reset_l high
        for (int v = 0; v < 12; v++) begin
            reset_l = tbl[v].rl; req = tbl[v].rq; blocked = tbl[v].bl; clear = tbl[v].cl;
            tick();
            check($sformatf("tbl%0d_ack", v), ack, tbl[v].e_ack);
            check($sformatf("tbl%0d_done", v), done, tbl[v].e_done);
            check($sformatf("tbl%0d_timeout", v), timeout, 0);
            check($sformatf("tbl%0d_c0", v), count[CW-1:0], tbl[v].e_c0);
            check($sformatf("tbl%0d_c1", v), count[2*CW-1:CW], tbl[v].e_c1);
        end
        req = '0; blocked = '0; clear = '0;

        // 25 requests spaced 3 cycles walk count0 up to TARGET
        clear = 2'b01;
        tick();
        clear = '0;
        for (int k = 1; k <= TGT; k++) begin
            req = 2'b01;
            tick();
            check("seq_accept_noack", ack[0], 0);
            req = '0;
            tick();
            check("seq_ack_lat2", ack[0], 1);
            check("seq_count0", count[CW-1:0], k);
            check("seq_done0", done[0], (k == TGT));
            check("seq_count1", count[2*CW-1:CW], 0);
            tick();
            check("seq_ack_pulse", ack[0], 0);
        end

        // DONE ignores requests until clear
        for (int k = 0; k < 3; k++) begin
            req = 2'b01;
            tick();
            req = '0;
            tick();
            check("done_noack", ack[0], 0);
            check("done_count", count[CW-1:0], TGT);
            check("done_level", done[0], 1);
        end
        clear = 2'b01;
        tick();
        clear = '0;
        check("clr_count", count[CW-1:0], 0);
        check("clr_done", done[0], 0);

        run_req(0, 10, lat);
        check("lat_unblocked", lat, 2);
        check("lat_unblocked_cnt", count[CW-1:0], 1);
        tick();
        check("lat_unblocked_pulse", ack[0], 0);

        run_req(6, 20, lat);
        check("lat_blk5", lat, 7);
        check("lat_blk5_cnt", count[CW-1:0], 2);
        check("lat_blk5_tout", timeout[0], 0);

`ifdef TICK_WAIT_TIMEOUT_EN
        run_req(1000, 40, lat);
        check("lat_expiry", lat, WMAX + 2);
        check("expiry_cnt", count[CW-1:0], 2);
        check("expiry_tout", timeout[0], 1);
        tick();
        check("expiry_pulse", ack[0], 0);
        run_req(0, 10, lat);
        check("sticky_lat", lat, 2);
        check("sticky_cnt", count[CW-1:0], 3);
        check("sticky_tout", timeout[0], 1);
        clear = 2'b01;
        tick();
        clear = '0;
        check("clr_tout", timeout[0], 0);
`else
        run_req(300, 310, lat);
        check("lat_noexpiry", lat, 301);
        check("noexpiry_cnt", count[CW-1:0], 3);
        check("noexpiry_tout", timeout[0], 0);
        clear = 2'b01;
        tick();
        clear = '0;
`endif

        // clear beats a same-cycle req in IDLE
        req = 2'b01; clear = 2'b01;
        tick();
        req = '0; clear = '0;
        check("reqclr_ack", ack[0], 0);
        check("reqclr_cnt", count[CW-1:0], 0);
        tick();
        check("reqclr_not_waiting", ack[0], 0);

        // reset mid-WAIT abandons the request
        req = 2'b01;
        tick();
        req = '0; reset_l = 1'b0;
        tick();
        check("rstwait_ack", ack, 0);
        check("rstwait_count", count, 0);
        check("rstwait_done", done, 0);
        check("rstwait_tout", timeout, 0);
        reset_l = 1'b1;
        tick();
        check("rstwait_noack1", ack[0], 0);
        tick();
        check("rstwait_noack2", ack[0], 0);

        // randomized traffic with blocked bursts, rare clears and resets
        for (int i = 0; i < CH; i++) blk_left[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            reset_l = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < CH; i++) begin
                req[i]   = ($urandom_range(0, 2) == 0);
                clear[i] = ($urandom_range(0, 59) == 0);
                if (blk_left[i] == 0 && $urandom_range(0, 7) == 0)
                    blk_left[i] = $urandom_range(1, 24);
                blocked[i] = (blk_left[i] > 0);
                if (blk_left[i] > 0) blk_left[i]--;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tick_wait_counter.md
TICK_WAIT_COUNTER -- requirements
Module: tick_wait_counter

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent channels (legal range 1..8).
REQ-002 SHALL have parameter CNT_W, default 8, width of each channel event counter.
REQ-003 SHALL have parameter TARGET, default 25, count value that completes a channel (legal range 1..2^CNT_W-1).
REQ-004 SHALL have parameter WAIT_MAX, default 15, maximum cycles a channel waits on blocked (legal range 1..255).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset_l  input  1  synchronous, active-low reset.
REQ-007 SHALL have port req  input  CHANNELS  per-channel single-cycle count request.
REQ-008 SHALL have port blocked  input  CHANNELS  per-channel hold-off; increment deferred while high.
REQ-009 SHALL have port clear  input  CHANNELS  per-channel synchronous restart.
REQ-010 SHALL have port ack  output  CHANNELS  one-cycle pulse; request retired.
REQ-011 SHALL have port count  output  CHANNELS*CNT_W  channel i counter at bits [i*CNT_W +: CNT_W].
REQ-012 SHALL have port done  output  CHANNELS  level; channel reached TARGET.
REQ-013 SHALL have port timeout  output  CHANNELS  sticky; a wait expired.

Function
REQ-014 SHALL implement one FSM per channel with states IDLE, WAIT, DONE; channels fully independent.
REQ-015 IDLE: req=1 SHALL move to WAIT at next edge, wait counter loaded 0; req=0 stays IDLE.
REQ-016 WAIT, blocked=0: at next edge count SHALL increment by 1, ack=1 for exactly one cycle, state -> IDLE, or -> DONE if new count equals TARGET.
REQ-017 WAIT, blocked=1: wait counter SHALL increment each cycle; when it equals WAIT_MAX, next edge sets timeout=1, pulses ack, leaves count unchanged, state -> IDLE.
REQ-018 req-to-ack latency SHALL be 2 cycles with blocked low throughout; WAIT_MAX+2 cycles on expiry.
REQ-019 req SHALL be ignored in WAIT and DONE; no queuing, no ack for dropped requests.
REQ-020 DONE: done=1 held, count frozen at TARGET, req ignored, until clear or reset.
REQ-021 clear[i]=1 SHALL at next edge force channel i to IDLE with count=0, done=0, timeout=0, ack=0, regardless of state; clear wins over simultaneous req, increment or expiry.
REQ-022 count SHALL never wrap; TARGET bounds it below 2^CNT_W.
REQ-023 timeout SHALL remain set across further successful requests until clear or reset.
REQ-024 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-025 reset_l=0 sampled at an edge SHALL force every channel to IDLE, count=0, wait counter=0, ack=0, done=0, timeout=0, overriding clear, req and blocked.
REQ-026 Reset asserted mid-WAIT SHALL abandon the request with no ack issued.
REQ-027 First req SHALL be accepted on the first edge with reset_l=1.

Configuration
REQ-028 Macro TICK_WAIT_TIMEOUT_EN defined: WAIT_MAX expiry behaviour per REQ-017 compiled in.
REQ-029 Macro TICK_WAIT_TIMEOUT_EN undefined: wait counter removed, WAIT holds indefinitely while blocked=1, timeout tied to 0, WAIT_MAX ignored.

Verification
REQ-030 CHANNELS=2, TARGET=25, blocked=0, 25 req pulses on ch0 spaced 3 cycles -> 25 acks, count0 steps 0..25, done0=1 after 25th ack, ch1 count stays 0.
REQ-031 Timeout enabled, WAIT_MAX=15, blocked0 held 1, one req -> ack0 exactly 17 cycles after req, timeout0=1, count0 unchanged.
REQ-032 blocked0 high 5 cycles then low, WAIT_MAX=15 -> ack0 7 cycles after req, count0+1, timeout0=0.
REQ-033 done0=1, further req pulses -> no ack, count0 stays 25; clear0 pulse -> next cycle count0=0, done0=0.
REQ-034 req0 and clear0 same cycle while IDLE -> channel stays IDLE, no ack; reset_l=0 during WAIT -> all outputs 0 next cycle, no ack.
REQ-035 Timeout disabled, blocked0 high 300 cycles -> no ack, timeout0=0; blocked0 low -> ack0 within 1 cycle, count0+1.
